io_scan_ctrl: RTL and testbench

Sequencer for the memory-mapped image region. On a start pulse it walks every pixel of the original-image region and reads each one. It applies a per-pixel operation and writes the result to the same offset in the processed-image region. It shares the IO data bus with the CPU, yields to CPU accesses, and reports `busy` and `done` so software can poll the show/status words.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_pixel_op.sv | 23 ++
 rtl/io_scan_ctrl.sv | 110 +++++++++++
 tb/tb_io_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO map constants and the scan sequencer state type, so the
// image region layout is defined in one place for decoder and scanner.
package io_pkg;

    localparam int IO_ORIG_BASE = 120;
    localparam int IO_PROC_BASE = 307320;
    localparam int IO_NPIX      = 307200;
    localparam int IO_AW        = 22;
    localparam int IO_DW        = 8;
    localparam int IO_IDX_W     = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } io_scan_state_t;

endpackage

// File: rtl/io_pixel_op.sv
// Combinational per-pixel operation: inversion by default, or a binary
// threshold against `thresh` when IO_SCAN_THRESH_EN is defined.
module io_pixel_op #(
    parameter int DW = 8
) (
`ifdef IO_SCAN_THRESH_EN
    input  logic [DW-1:0] thresh,
`endif
    input  logic [DW-1:0] pixel,
    output logic [DW-1:0] result
);

`ifdef IO_SCAN_THRESH_EN
    always_comb begin
        result = (pixel >= thresh) ? {DW{1'b1}} : {DW{1'b0}};
    end
`else
    always_comb begin
        result = {DW{1'b1}} - pixel;
    end
`endif

endmodule

// File: rtl/io_scan_ctrl.sv
// Frame scan sequencer: reads each original pixel, writes op(pixel) to the
// processed region, yielding the bus to the CPU. Optional: IO_SCAN_THRESH_EN.
module io_scan_ctrl
    import io_pkg::*;
#(
    parameter int NPIX      = IO_NPIX,
    parameter int ORIG_BASE = IO_ORIG_BASE,
    parameter int PROC_BASE = IO_PROC_BASE,
    parameter int AW        = 22,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cpu_req,
    input  logic [DW-1:0] rd_data,
`ifdef IO_SCAN_THRESH_EN
    input  logic [DW-1:0] thresh,
`endif
    output logic [AW-1:0] addr,
    output logic          rd_en,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam logic [IO_IDX_W-1:0] LAST_IDX = IO_IDX_W'(NPIX - 1);

    io_scan_state_t       state_q, state_d;
    logic [IO_IDX_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]        pix_q;
    logic [DW-1:0]        op_out;

    io_pixel_op #(.DW(DW)) u_op (
`ifdef IO_SCAN_THRESH_EN
        .thresh (thresh),
`endif
        .pixel  (pix_q),
        .result (op_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // The read was issued last cycle, so capture even if the CPU now owns the bus.
            if (state_q == ST_WAIT) begin
                pix_q <= rd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr    = '0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!cpu_req) begin
                    rd_en   = 1'b1;
                    addr    = AW'(ORIG_BASE) + AW'(idx_q);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!cpu_req) begin
                    wr_en   = 1'b1;
                    addr    = AW'(PROC_BASE) + AW'(idx_q);
                    wr_data = op_out;
                    if (idx_q == LAST_IDX) begin
                        // Software sees busy drop together with the done pulse.
                        done    = 1'b1;
                        busy    = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Directed bench for io_scan_ctrl with a 4-pixel frame, a registered
// memory model and a write scoreboard.
module tb_io_scan_ctrl;
    import io_pkg::*;

    localparam logic [21:0] ORIG = 22'd120;
    localparam logic [21:0] PROC = 22'd307320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cpu_req = 1'b0;
    logic [7:0]  rd_data = 8'h00;
`ifdef IO_SCAN_THRESH_EN
    logic [7:0]  thresh = 8'd25;
`endif
    logic [21:0] addr;
    logic        rd_en, wr_en, busy, done;
    logic [7:0]  wr_data;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int done_count = 0;
    bit mon_en = 1'b0;

    logic [7:0]  mem [4];
    logic [7:0]  exp_q[$];
    logic [21:0] exp_a_q[$];

    io_scan_ctrl #(.NPIX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cpu_req   (cpu_req),
        .rd_data   (rd_data),
`ifdef IO_SCAN_THRESH_EN
        .thresh    (thresh),
`endif
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: data valid the cycle after rd_en, junk otherwise
    always @(posedge clk) begin
        if (rd_en && addr >= ORIG && addr < ORIG + 22'd4) begin
            rd_data <= mem[2'(addr - ORIG)];
        end else begin
            rd_data <= 8'h5A;
        end
    end

    // per-cycle monitor and write scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (rd_en && wr_en) begin
                bad++;
                $display("FAIL excl: rd_en=%0b wr_en=%0b both high", rd_en, wr_en);
            end
            if (cpu_req) begin
                total++;
                if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL cpu_stall: rd_en=%0b wr_en=%0b required 0", rd_en, wr_en);
                end
            end
            if (!rd_en && !wr_en) begin
                total++;
                if (addr !== 22'd0) begin
                    bad++;
                    $display("FAIL idle_addr: addr=%0d required 0", addr);
                end
            end
            if (rd_en) begin
                total++;
                if (addr < ORIG || addr > ORIG + 22'd3) begin
                    bad++;
                    $display("FAIL rd_range: addr=%0d required 120..123", addr);
                end
            end
            if (wr_en) begin
                wr_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexp: addr=%0d data=%0d with no write expected", addr, wr_data);
                end else begin
                    logic [7:0]  ed;
                    logic [21:0] ea;
                    ed = exp_q.pop_front();
                    ea = exp_a_q.pop_front();
                    if (addr !== ea || wr_data !== ed) begin
                        bad++;
                        $display("FAIL wr: addr=%0d data=%0d required addr=%0d data=%0d", addr, wr_data, ea, ed);
                    end
                end
            end
            if (done) done_count++;
        end
    end

    // driver tasks
    task automatic load_mem(input logic [7:0] p0, p1, p2, p3);
        mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    endtask

    task automatic push_exp(input logic [7:0] d0, d1, d2, d3);
        exp_q.push_back(d0); exp_a_q.push_back(PROC);
        exp_q.push_back(d1); exp_a_q.push_back(PROC + 22'd1);
        exp_q.push_back(d2); exp_a_q.push_back(PROC + 22'd2);
        exp_q.push_back(d3); exp_a_q.push_back(PROC + 22'd3);
    endtask

    // Pulses start, then cycle n=1 is the first READ cycle. cpu_req is driven
    // over [s_lo,s_hi] and at cycle extra; start re-pulsed at ra and rb.
    task automatic run_frame(input int s_lo, input int s_hi, input int extra,
                             input int ra, input int rb,
                             output int done_cyc, output logic done_busy,
                             output logic first_busy, output logic first_rd);
        done_cyc = 0;
        done_busy = 1'bx;
        first_busy = 1'bx;
        first_rd = 1'bx;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            cpu_req = ((n >= s_lo) && (n <= s_hi)) || (n == extra);
            start = (n == ra) || (n == rb);
            @(negedge clk);
            if (n == 1) begin
                first_busy = busy;
                first_rd = rd_en;
            end
            if (done) begin
                done_cyc = n;
                done_busy = busy;
                break;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (addr !== 22'd0 || rd_en !== 1'b0 || wr_en !== 1'b0 || wr_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_bus: addr=%0d rd=%0b wr=%0b data=%0d required all 0", addr, rd_en, wr_en, wr_data);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%0b done=%0b required 0 0", busy, done);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        mon_en = 1'b1;
    endtask

    task automatic check_frame_end(input string tag, input int done_cyc, input int exp_cyc,
                                   input logic done_busy, input int d0, input int w0, input int exp_w);
        total++;
        if (done_cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s_done_cyc: done at cycle %0d required %0d", tag, done_cyc, exp_cyc);
        end
        total++;
        if (done_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: busy=%0b required 0", tag, done_busy);
        end
        idle_cycles(6);
        total++;
        if (done_count - d0 != 1 || wr_count - w0 != exp_w) begin
            bad++;
            $display("FAIL %s_counts: dones=%0d writes=%0d required 1 %0d", tag, done_count - d0, wr_count - w0, exp_w);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d writes outstanding required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_basic_frame();
        int dc, d0, w0;
        logic db, fb, fr;
        load_mem(8'd10, 8'd20, 8'd30, 8'd40);
`ifdef IO_SCAN_THRESH_EN
        push_exp(8'd0, 8'd0, 8'd255, 8'd255);
`else
        push_exp(8'd245, 8'd235, 8'd225, 8'd215);
`endif
        d0 = done_count; w0 = wr_count;
        run_frame(0, -1, 0, 0, 0, dc, db, fb, fr);
        total++;
        if (fb !== 1'b1 || fr !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: busy=%0b rd_en=%0b in first cycle required 1 1", fb, fr);
        end
        check_frame_end("basic", dc, 12, db, d0, w0, 4);
    endtask

    task automatic test_cpu_stall();
        int dc, d0, w0;
        logic db, fb, fr;
        load_mem(8'd10, 8'd20, 8'd30, 8'd40);
`ifdef IO_SCAN_THRESH_EN
        push_exp(8'd0, 8'd0, 8'd255, 8'd255);
`else
        push_exp(8'd245, 8'd235, 8'd225, 8'd215);
`endif
        d0 = done_count; w0 = wr_count;
        // stall pixel 1 READ for 5 cycles, and cpu_req during pixel 2 WAIT (cycle 13)
        run_frame(4, 8, 13, 0, 0, dc, db, fb, fr);
        check_frame_end("stall", dc, 17, db, d0, w0, 4);
    endtask

    task automatic test_back_to_back();
        int dc, d0, w0;
        logic db, fb, fr;
        load_mem(8'd0, 8'd255, 8'd128, 8'd1);
`ifdef IO_SCAN_THRESH_EN
        push_exp(8'd0, 8'd255, 8'd255, 8'd0);
`else
        push_exp(8'd255, 8'd0, 8'd127, 8'd254);
`endif
        d0 = done_count; w0 = wr_count;
        run_frame(0, -1, 0, 5, 11, dc, db, fb, fr);
        check_frame_end("restart", dc, 12, db, d0, w0, 4);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_queued: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int dc, d0, w0;
        logic db, fb, fr;
        load_mem(8'd25, 8'd24, 8'd7, 8'd200);
`ifdef IO_SCAN_THRESH_EN
        push_exp(8'd255, 8'd0, 8'd0, 8'd255);
`else
        push_exp(8'd230, 8'd231, 8'd248, 8'd55);
`endif
        d0 = done_count; w0 = wr_count;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // cycles 1..6 cover two complete pixels; reset during cycle 7
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (addr !== 22'd0 || rd_en !== 1'b0 || wr_en !== 1'b0 || wr_data !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: addr=%0d rd=%0b wr=%0b data=%0d busy=%0b done=%0b required all 0",
                     addr, rd_en, wr_en, wr_data, busy, done);
        end
        idle_cycles(15);
        total++;
        if (wr_count - w0 != 2 || done_count != d0) begin
            bad++;
            $display("FAIL midrst_abandon: writes=%0d dones=%0d required 2 0", wr_count - w0, done_count - d0);
        end
        exp_q.delete();
        exp_a_q.delete();
`ifdef IO_SCAN_THRESH_EN
        push_exp(8'd255, 8'd0, 8'd0, 8'd255);
`else
        push_exp(8'd230, 8'd231, 8'd248, 8'd55);
`endif
        d0 = done_count; w0 = wr_count;
        run_frame(0, -1, 0, 0, 0, dc, db, fb, fr);
        check_frame_end("midrst_rerun", dc, 12, db, d0, w0, 4);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cpu_stall();
        test_back_to_back();
        test_mid_reset();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
